ex_muldiv_unit: RTL and testbench
=================================

# ex_muldiv_unit

Iterative multiply/divide unit with integrated HI/LO registers for the EX stage. It extends the single-cycle MTHI/MTLO/MFHI/MFLO path with MULT, MULTU, DIV and DIVU over a parametrised operand width. It computes one bit per cycle and raises a stall request so the pipeline freezes until HI/LO hold the result. It sits beside the ALU in EX; MFHI/MFLO read `hi_o`/`lo_o` directly.

## Interface
- `WIDTH`, default 32: operand and HI/LO width; must be even and ≥ 4.
- `CNT_W`, default $clog2(WIDTH)+1: iteration counter width (derived, not overridden).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: request; sampled with `op`, `src_a`, `src_b` at a rising edge.
- `op` in 3: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op.
- `src_a` in WIDTH: multiplicand / dividend / MTHI-MTLO data.
- `src_b` in WIDTH: multiplier / divisor.
- `cancel` in 1: flush from branch/exception; aborts any operation in flight.
- `hi_o` out WIDTH: HI register.
- `lo_o` out WIDTH: LO register.
- `busy` out 1: registered, high while state ≠ IDLE.
- `stall_req` out 1: combinational, `busy | (start & state==IDLE & op is MULT/MULTU/DIV/DIVU & !cancel)`.
- `done` out 1: registered, one-cycle pulse after a mul/div result is written.

## Operation
- States: IDLE, CALC, FIN.
- IDLE + `start` + mul/div op, no `cancel`:
  - Latch the absolute values of the operands; unsigned ops use them raw.
  - Latch the result-sign flags.
  - Set counter = 0 and go to CALC.
- Divide by zero (DIV/DIVU with `src_b` = 0): go straight to FIN with preset result HI = `src_a`, LO = all ones.
- IDLE + `start` + MTHI/MTLO: write HI or LO with `src_a` at that edge. State stays IDLE, no stall, no `done`.
- CALC, multiply: shift-add, one multiplier bit per edge into a 2·WIDTH accumulator.
- CALC, divide: restoring division, one quotient bit per edge.
- CALC exits to FIN after exactly WIDTH edges (counter reaches WIDTH).
- FIN: apply the sign fixup and write HI/LO; go to IDLE; set `done`=1 for the next cycle.
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the dividend's sign.
  - Multiply: HI = product[2W-1:W], LO = product[W-1:0].
  - Divide: LO = quotient, HI = remainder.
- Signed overflow (DIV of MIN by −1): LO = MIN, HI = 0. This falls out of the unsigned datapath; no special case.
- `cancel` (any state):
  - Next edge goes to IDLE, HI/LO unchanged, `done` stays 0.
  - `cancel` has priority over `start` in the same cycle, including MTHI/MTLO.
- `start` while `busy`: ignored, including MTHI/MTLO.
- Reset (async, any time):
  - State IDLE; HI = 0, LO = 0; `busy` = 0, `done` = 0, counter = 0.
  - Any in-flight result is lost.

## Timing
- Accept edge E0, for mul/div:
  - Iterations at E1..EW.
  - HI/LO written at E(W+1).
  - `done` high for the cycle between E(W+1) and E(W+2).
- `stall_req` is high from the cycle `start` is presented through the cycle ending at E(W+1). That is W+2 cycles, 34 for WIDTH=32. It is low in the cycle `done` is high, and `hi_o`/`lo_o` already show the new value in that cycle.
- Divide by zero: stall covers 2 cycles (E0, E1); HI/LO written at E1.
- MTHI/MTLO: visible on `hi_o`/`lo_o` the cycle after the edge; zero stall.
- A new `start` is legal in the same cycle `done` is high.
- `busy` rises the cycle after E0 and falls the cycle after E(W+1).

## Test plan
- Reset low mid-CALC of MULT 3×5 -> `hi_o`=`lo_o`=0, `busy`=0 immediately. After release, no `done` pulse.
- MULT src_a=0xFFFFFFFD (−3), src_b=7 -> `stall_req` high 34 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB, `done` one cycle. MULTU 0xFFFFFFFF×2 -> HI=1, LO=0xFFFFFFFE.
- DIVU 100/7 -> LO=14, HI=2. DIV −7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 5/0 -> HI=5, LO=0xFFFFFFFF after 2 stall cycles, `done` pulses.
- MTHI 0x1234 then MTLO 0xABCD on consecutive cycles -> `hi_o`=0x1234, `lo_o`=0xABCD, `stall_req` never high. MTHI during CALC -> ignored.
- `cancel` at counter=10 of DIV -> IDLE next edge, HI/LO retain prior values, no `done`. `cancel`+`start` same cycle -> nothing accepted. Back-to-back start in the `done` cycle -> accepted.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO registers and MTHI/MTLO for the EX stage
module ex_muldiv_unit #(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy,
  output logic             stall_req,
  output logic             done
);
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, FIN = 2'd2;
  logic [1:0] r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi, r_lo, r_opd;
  logic [2*WIDTH-1:0] r_acc;
  logic r_div, r_neg_q, r_neg_r, r_busy, r_done;
  logic w_signed, w_div, w_muldiv, w_go, w_dz;
  logic [WIDTH-1:0] w_abs_a, w_abs_b, w_quo, w_rem;
  logic [WIDTH:0] w_sum, w_trial;
  logic [2*WIDTH-1:0] w_step, w_prod;
  assign w_signed = !op[0];
  assign w_div = op[1];
  assign w_muldiv = !op[2];
  assign w_go = start & (r_state == IDLE) & !cancel;
  assign w_dz = w_div & (src_b == '0);
  assign w_abs_a = (w_signed & src_a[WIDTH-1]) ? -src_a : src_a;
  assign w_abs_b = (w_signed & src_b[WIDTH-1]) ? -src_b : src_b;
  // Multiply: product enters from the top while multiplier bits leave the bottom.
  // Divide: dividend bits shift into the remainder half, quotient bits fill in below.
  assign w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opd} : '0);
  assign w_trial = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opd};
  assign w_step = !r_div ? {w_sum, r_acc[WIDTH-1:1]} :
                  w_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0} :
                  {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quo = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  assign hi_o = r_hi;
  assign lo_o = r_lo;
  assign busy = r_busy;
  assign done = r_done;
  assign stall_req = r_busy | (w_go & w_muldiv);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_hi <= '0;
      r_lo <= '0;
      r_opd <= '0;
      r_acc <= '0;
      r_div <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (cancel) begin
        r_state <= IDLE;
        r_busy <= 1'b0;
        r_cnt <= '0;
      end else if (r_state == CALC) begin
        r_acc <= w_step;
        r_cnt <= r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= FIN;
      end else if (r_state == FIN) begin
        r_hi <= r_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
        r_lo <= r_div ? w_quo : w_prod[WIDTH-1:0];
        r_state <= IDLE;
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end else if (w_go & w_muldiv) begin
        // Divide by zero skips the iterations with the result preset; sign flags cleared so FIN passes it through.
        r_state <= w_dz ? FIN : CALC;
        r_busy <= 1'b1;
        r_cnt <= '0;
        r_div <= w_div;
        r_opd <= w_div ? w_abs_b : w_abs_a;
        r_acc <= w_dz ? {src_a, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, w_div ? w_abs_a : w_abs_b};
        r_neg_q <= !w_dz & w_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
        r_neg_r <= !w_dz & w_div & w_signed & src_a[WIDTH-1];
      end else if (w_go & (op == 3'b100)) begin
        r_hi <= src_a;
      end else if (w_go & (op == 3'b101)) begin
        r_lo <= src_a;
      end
    end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: scoreboard bench for the iterative mul/div unit at WIDTH=32
module tb_ex_muldiv_unit;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, cancel = 1'b0;
  logic [2:0] op = 3'b000;
  logic [31:0] src_a = '0, src_b = '0;
  logic [31:0] hi_o, lo_o;
  logic busy, stall_req, done;
  int n_checks = 0, n_fail = 0;
  logic [63:0] sb_q[$];
  logic [63:0] cur_hl = '0;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .cancel(cancel), .hi_o(hi_o), .lo_o(lo_o), .busy(busy), .stall_req(stall_req), .done(done)
  );

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa = $signed(a);
    longint sb = $signed(b);
    longint unsigned ua = {32'h0, a};
    longint unsigned ub = {32'h0, b};
    if (o == 3'd0) return sa * sb;
    if (o == 3'd1) return ua * ub;
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (o == 3'd2) return {32'(sa % sb), 32'(sa / sb)};
    return {32'(ua % ub), 32'(ua / ub)};
  endfunction

  // Presents the request mid-cycle, then follows it to its done pulse; returns in the done cycle.
  task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int mt_at);
    int stalls;
    int exp_stall;
    bit seen = 0;
    logic [63:0] e;
    exp_stall = (o[1] && b == 32'h0) ? 2 : 34;
    sb_q.push_back(model(o, a, b));
    start = 1'b1; op = o; src_a = a; src_b = b;
    #1;
    stalls = int'(stall_req);
    for (int k = 0; k < 200 && !seen; k++) begin
      @(posedge clk); #1;
      if (k == mt_at) begin start = 1'b1; op = 3'b100; src_a = 32'hDEAD_BEEF; end
      else start = 1'b0;
      #1;
      if (done) seen = 1;
      else if (stall_req) stalls++;
    end
    e = sb_q.pop_front();
    n_checks++;
    if (!seen) begin
      $display("FAIL done_timeout op=%0d: done never seen, required within 200 cycles", o);
      n_fail++;
      return;
    end
    cur_hl = e;
    n_checks += 4;
    if (hi_o !== e[63:32]) begin $display("FAIL hi op=%0d a=%h b=%h: got %h want %h", o, a, b, hi_o, e[63:32]); n_fail++; end
    if (lo_o !== e[31:0]) begin $display("FAIL lo op=%0d a=%h b=%h: got %h want %h", o, a, b, lo_o, e[31:0]); n_fail++; end
    if (stalls !== exp_stall) begin $display("FAIL stall_len op=%0d: got %0d want %0d", o, stalls, exp_stall); n_fail++; end
    if (stall_req !== 1'b0) begin $display("FAIL stall_in_done op=%0d: got %b want 0", o, stall_req); n_fail++; end
  endtask

  task automatic test_reset;
    int pulses = 0;
    #12;
    n_checks += 5;
    if (hi_o !== 32'h0) begin $display("FAIL rst_hi: got %h want 0", hi_o); n_fail++; end
    if (lo_o !== 32'h0) begin $display("FAIL rst_lo: got %h want 0", lo_o); n_fail++; end
    if (busy !== 1'b0) begin $display("FAIL rst_busy: got %b want 0", busy); n_fail++; end
    if (done !== 1'b0) begin $display("FAIL rst_done: got %b want 0", done); n_fail++; end
    if (stall_req !== 1'b0) begin $display("FAIL rst_stall: got %b want 0", stall_req); n_fail++; end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; start = 1'b1; op = 3'b100; src_a = 32'h55;
    @(posedge clk); #1; op = 3'b101; src_a = 32'h66;
    @(posedge clk); #1; op = 3'b000; src_a = 32'd3; src_b = 32'd5;
    n_checks += 2;
    if (hi_o !== 32'h55) begin $display("FAIL pre_rst_hi: got %h want 55", hi_o); n_fail++; end
    if (lo_o !== 32'h66) begin $display("FAIL pre_rst_lo: got %h want 66", lo_o); n_fail++; end
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #3; rst = 1'b0; #1;
    n_checks += 3;
    if (hi_o !== 32'h0) begin $display("FAIL midcalc_rst_hi: got %h want 0", hi_o); n_fail++; end
    if (lo_o !== 32'h0) begin $display("FAIL midcalc_rst_lo: got %h want 0", lo_o); n_fail++; end
    if (busy !== 1'b0) begin $display("FAIL midcalc_rst_busy: got %b want 0", busy); n_fail++; end
    #3; rst = 1'b1;
    repeat (40) begin @(posedge clk); #1; if (done) pulses++; end
    n_checks++;
    if (pulses !== 0) begin $display("FAIL post_rst_done: got %0d pulses want 0", pulses); n_fail++; end
    cur_hl = '0;
  endtask

  task automatic test_mult;
    run(3'd0, 32'hFFFF_FFFD, 32'd7, -1);
    @(posedge clk); #2;
    n_checks++;
    if (done !== 1'b0) begin $display("FAIL done_width: got %b want 0", done); n_fail++; end
    run(3'd1, 32'hFFFF_FFFF, 32'd2, -1);
    run(3'd0, 32'h8000_0000, 32'h8000_0000, -1);
    run(3'd0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, -1);
  endtask

  task automatic test_div;
    logic [2:0] o;
    logic [31:0] a, b;
    run(3'd3, 32'd100, 32'd7, -1);
    run(3'd2, 32'hFFFF_FFF9, 32'd2, -1);
    run(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    for (int i = 0; i < 6; i++) begin
      o = 3'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom >> $urandom_range(0, 28);
      run(o, a, b, -1);
    end
  endtask

  task automatic test_divzero;
    run(3'd3, 32'd5, 32'd0, -1);
    run(3'd2, 32'hFFFF_FFF7, 32'd0, -1);
  endtask

  task automatic test_mtx;
    @(posedge clk); #1; start = 1'b1; op = 3'b100; src_a = 32'h1234;
    #1;
    n_checks++;
    if (stall_req !== 1'b0) begin $display("FAIL mthi_stall: got %b want 0", stall_req); n_fail++; end
    @(posedge clk); #1; op = 3'b101; src_a = 32'hABCD;
    #1;
    n_checks += 2;
    if (stall_req !== 1'b0) begin $display("FAIL mtlo_stall: got %b want 0", stall_req); n_fail++; end
    if (hi_o !== 32'h1234) begin $display("FAIL mthi_val: got %h want 1234", hi_o); n_fail++; end
    @(posedge clk); #1; start = 1'b0;
    #1;
    n_checks += 3;
    if (lo_o !== 32'hABCD) begin $display("FAIL mtlo_val: got %h want abcd", lo_o); n_fail++; end
    if (hi_o !== 32'h1234) begin $display("FAIL mthi_hold: got %h want 1234", hi_o); n_fail++; end
    if (busy !== 1'b0 || done !== 1'b0) begin $display("FAIL mt_busy_done: got %b%b want 00", busy, done); n_fail++; end
    run(3'd1, 32'd6, 32'd7, 3);
  endtask

  task automatic test_cancel;
    int pulses = 0;
    @(posedge clk); #1; start = 1'b1; op = 3'b010; src_a = 32'd1000; src_b = 32'd3;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b1) begin $display("FAIL cancel_pre_busy: got %b want 1", busy); n_fail++; end
    cancel = 1'b1;
    @(posedge clk); #1; cancel = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin $display("FAIL cancel_busy: got %b want 0", busy); n_fail++; end
    repeat (40) begin @(posedge clk); #1; if (done) pulses++; end
    n_checks += 2;
    if (pulses !== 0) begin $display("FAIL cancel_done: got %0d pulses want 0", pulses); n_fail++; end
    if ({hi_o, lo_o} !== cur_hl) begin $display("FAIL cancel_hilo: got %h want %h", {hi_o, lo_o}, cur_hl); n_fail++; end
    start = 1'b1; op = 3'b000; src_a = 32'd9; src_b = 32'd9; cancel = 1'b1;
    #1;
    n_checks++;
    if (stall_req !== 1'b0) begin $display("FAIL cancel_start_stall: got %b want 0", stall_req); n_fail++; end
    @(posedge clk); #1; op = 3'b100; src_a = 32'hFFFF;
    n_checks++;
    if (busy !== 1'b0) begin $display("FAIL cancel_start_busy: got %b want 0", busy); n_fail++; end
    @(posedge clk); #1; start = 1'b0; cancel = 1'b0;
    n_checks++;
    if ({hi_o, lo_o} !== cur_hl) begin $display("FAIL cancel_mthi: got %h want %h", {hi_o, lo_o}, cur_hl); n_fail++; end
  endtask

  task automatic test_back_to_back;
    run(3'd3, 32'd100, 32'd7, -1);
    run(3'd0, 32'h0001_2345, 32'hFFFF_FCDF, -1);
    run(3'd3, 32'd9, 32'd0, -1);
    run(3'd2, 32'hFFFF_FF00, 32'd7, -1);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_divzero();
    test_mtx();
    test_cancel();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
